// File: rtl/button_judge.sv
// Hit judgement for the red/blue lanes: detects a fresh button press, matches it
// against the colour of the nearest note and grades the hit from the note's row offset.
module button_judge #(
   parameter int unsigned PERFECT_LO = 3,
   parameter int unsigned PERFECT_HI = 4,
   parameter int unsigned GREAT_LO   = 2,
   parameter int unsigned GREAT_HI   = 5,
   parameter int unsigned GOOD_LO    = 1,
   parameter int unsigned GOOD_HI    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       red_button,
   input  logic       blue_button,
   input  logic [2:0] offset,
   input  logic       node_R,
   input  logic       node_B,
   output logic       delete_note,
   output logic [1:0] score
);

   localparam logic [2:0] PERF_LO = PERFECT_LO[2:0];
   localparam logic [2:0] PERF_HI = PERFECT_HI[2:0];
   localparam logic [2:0] GRT_LO  = GREAT_LO[2:0];
   localparam logic [2:0] GRT_HI  = GREAT_HI[2:0];
   localparam logic [2:0] GD_LO   = GOOD_LO[2:0];
   localparam logic [2:0] GD_HI   = GOOD_HI[2:0];

   localparam logic [1:0] SCORE_NONE    = 2'b00;
   localparam logic [1:0] SCORE_GOOD    = 2'b01;
   localparam logic [1:0] SCORE_GREAT   = 2'b10;
   localparam logic [1:0] SCORE_PERFECT = 2'b11;

   logic       red_prev;
   logic       blue_prev;
   logic       red_press;
   logic       blue_press;
   logic       red_hit;
   logic       blue_hit;
   logic [1:0] grade;
   logic       judge;

   // A press is consumed whether or not it hits; prev tracks the raw level every clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         red_prev  <= 1'b0;
         blue_prev <= 1'b0;
      end else begin
         red_prev  <= red_button;
         blue_prev <= blue_button;
      end
   end

   always_comb begin
      red_press  = red_button & ~red_prev;
      blue_press = blue_button & ~blue_prev;
      red_hit    = red_press & node_R;
      blue_hit   = blue_press & node_B;
   end

   // Only one nearest note exists, so both lanes share a single grade.
   always_comb begin
      grade = SCORE_NONE;
      if (offset >= PERF_LO && offset <= PERF_HI)
         grade = SCORE_PERFECT;
      else if (offset == GRT_LO || offset == GRT_HI)
         grade = SCORE_GREAT;
      else if (offset == GD_LO || offset == GD_HI)
         grade = SCORE_GOOD;
   end

   assign judge = (red_hit | blue_hit) && (grade != SCORE_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         delete_note <= 1'b0;
         score       <= SCORE_NONE;
      end else if (judge) begin
         delete_note <= 1'b1;
         score       <= grade;
      end else begin
         delete_note <= 1'b0;
         score       <= SCORE_NONE;
      end
   end

endmodule

// File: tb/tb_button_judge.sv
// Bench for button_judge: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the judgement rules.
module tb_button_judge;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       red_button = 1'b0;
   logic       blue_button = 1'b0;
   logic [2:0] offset = 3'd0;
   logic       node_R = 1'b0;
   logic       node_B = 1'b0;
   logic       delete_note;
   logic [1:0] score;

   int total = 0;
   int bad = 0;

   button_judge dut (
      .clk         (clk),
      .rst         (rst),
      .red_button  (red_button),
      .blue_button (blue_button),
      .offset      (offset),
      .node_R      (node_R),
      .node_B      (node_B),
      .delete_note (delete_note),
      .score       (score)
   );

   always #5 clk = ~clk;

   // Behavioural model: grade per offset from the window rules, last-seen button levels.
   int   grade_tab [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
   bit   m_red_last = 1'b0;
   bit   m_blue_last = 1'b0;
   bit   exp_del = 1'b0;
   int   exp_score = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_red_last  = 1'b0;
         m_blue_last = 1'b0;
         exp_del     = 1'b0;
         exp_score   = 0;
      end else begin
         bit fresh_red, fresh_blue, matched;
         int g;
         fresh_red  = red_button && !m_red_last;
         fresh_blue = blue_button && !m_blue_last;
         matched    = (fresh_red && node_R) || (fresh_blue && node_B);
         g          = grade_tab[offset];
         exp_del    = matched && (g != 0);
         exp_score  = exp_del ? g : 0;
         m_red_last  = red_button;
         m_blue_last = blue_button;
      end
   end

   always @(negedge clk) begin
      total++;
      if (delete_note !== exp_del || int'(score) != exp_score || $isunknown(score)) begin
         bad++;
         $display("FAIL model_cmp t=%0t: got del=%0b score=%0d, want del=%0b score=%0d",
                  $time, delete_note, score, exp_del, exp_score);
      end
   end

   task automatic check(input string name, input bit want_del, input logic [1:0] want_score);
      total++;
      if (delete_note !== want_del || score !== want_score) begin
         bad++;
         $display("FAIL %s: got del=%0b score=%0d, want del=%0b score=%0d",
                  name, delete_note, score, want_del, want_score);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_note(input logic [2:0] off, input bit r, input bit b);
      offset = off;
      node_R = r;
      node_B = b;
   endtask

   initial begin
      tick();
      tick();
      check("reset_state", 1'b0, 2'b00);
      rst = 1'b1;
      tick();
      check("after_release", 1'b0, 2'b00);

      set_note(3'd3, 1'b1, 1'b0); red_button = 1'b1; tick();
      check("red_perfect", 1'b1, 2'b11);
      red_button = 1'b0; tick();
      check("red_perfect_end", 1'b0, 2'b00);

      set_note(3'd5, 1'b0, 1'b1); blue_button = 1'b1; tick();
      check("blue_great_5", 1'b1, 2'b10);
      blue_button = 1'b0; tick();
      check("blue_great_end", 1'b0, 2'b00);

      set_note(3'd1, 1'b1, 1'b0); red_button = 1'b1; tick();
      check("red_good_1", 1'b1, 2'b01);
      red_button = 1'b0; tick();
      set_note(3'd6, 1'b1, 1'b0); red_button = 1'b1; tick();
      check("red_good_6", 1'b1, 2'b01);
      red_button = 1'b0; tick();

      set_note(3'd0, 1'b0, 1'b1); blue_button = 1'b1; tick();
      check("blue_off0", 1'b0, 2'b00);
      blue_button = 1'b0; tick();
      set_note(3'd7, 1'b0, 1'b1); blue_button = 1'b1; tick();
      check("blue_off7", 1'b0, 2'b00);
      blue_button = 1'b0; tick();

      set_note(3'd4, 1'b1, 1'b0); red_button = 1'b1; tick();
      check("hold_first", 1'b1, 2'b11);
      tick();
      check("hold_second", 1'b0, 2'b00);
      tick();
      check("hold_third", 1'b0, 2'b00);
      red_button = 1'b0; tick();
      red_button = 1'b1; tick();
      check("repress", 1'b1, 2'b11);
      red_button = 1'b0; tick();

      set_note(3'd3, 1'b1, 1'b0); blue_button = 1'b1; tick();
      check("wrong_lane", 1'b0, 2'b00);
      blue_button = 1'b0; tick();
      set_note(3'd2, 1'b1, 1'b0); red_button = 1'b1; blue_button = 1'b1; tick();
      check("both_press", 1'b1, 2'b10);
      tick();
      check("both_single", 1'b0, 2'b00);
      red_button = 1'b0; blue_button = 1'b0; tick();

      set_note(3'd0, 1'b1, 1'b0); red_button = 1'b1; tick();
      check("out_window_press", 1'b0, 2'b00);
      set_note(3'd3, 1'b1, 1'b0); tick();
      check("held_into_window", 1'b0, 2'b00);
      red_button = 1'b0; tick();

      set_note(3'd3, 1'b1, 1'b0); red_button = 1'b1; tick();
      check("pre_reset_pulse", 1'b1, 2'b11);
      #1 rst = 1'b0;
      #1 check("async_reset", 1'b0, 2'b00);
      #3 rst = 1'b1;
      tick();
      check("held_through_reset", 1'b1, 2'b11);
      tick();
      check("held_through_reset_end", 1'b0, 2'b00);

      for (int i = 0; i < 3000; i++) begin
         red_button  = ($urandom_range(0, 2) != 0) ? ~red_button : red_button;
         blue_button = ($urandom_range(0, 2) != 0) ? ~blue_button : blue_button;
         offset      = 3'($urandom_range(0, 7));
         node_R      = 1'($urandom);
         node_B      = 1'($urandom);
         if ($urandom_range(0, 99) == 0) rst = 1'b0;
         else rst = 1'b1;
         tick();
      end
      rst = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_judge.md
Name: button_judge

Overview:
- Hit-judgement block for the two-lane (red/blue) rhythm game.
- Detects a fresh press on each lane button and checks that a note of the matching colour is present at the judge window.
- Grades timing from the note's 3-bit row offset, then issues a one-cycle delete_note strobe and a 2-bit score to the note-memory and scoring logic.

Parameters:
- PERFECT_LO, 3, lowest offset graded Perfect
- PERFECT_HI, 4, highest offset graded Perfect
- GREAT_LO, 2, lower offset graded Great
- GREAT_HI, 5, upper offset graded Great
- GOOD_LO, 1, lower offset graded Good
- GOOD_HI, 6, upper offset graded Good

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- red_button  input  1  red lane button, level, already synchronised and debounced
- blue_button  input  1  blue lane button, level, already synchronised and debounced
- offset  input  3  row offset of the nearest note relative to the judge line, 0..7
- node_R  input  1  1 = nearest note is a red note
- node_B  input  1  1 = nearest note is a blue note
- delete_note  output  1  one-cycle strobe: judged note must be removed
- score  output  2  grade of the judged hit; valid only while delete_note=1

Behaviour:
- Reset (rst=0, asynchronous):
  - delete_note=0, score=2'b00.
  - Previous-button registers red_prev=0, blue_prev=0.
  - A button already high when reset releases therefore counts as a press on the first clock.
- Edge detect:
  - red_press = red_button & ~red_prev; blue_press likewise.
  - The prev registers load the current button value every clock.
  - Holding a button produces exactly one press; a new press requires a release (at least one sampled low) first.
- Lane match:
  - red_hit = red_press & node_R.
  - blue_hit = blue_press & node_B.
  - A press without the matching-colour note (wrong lane, or no note) is ignored: no delete, score 00. The press is still consumed.
- Grade (combinational from offset, applied to the selected hit):
  - offset in [PERFECT_LO,PERFECT_HI] gives 2'b11 (Perfect).
  - offset GREAT_LO or GREAT_HI gives 2'b10 (Great).
  - offset GOOD_LO or GOOD_HI gives 2'b01 (Good).
  - Any other offset (default 0, 7) is out of window: no judgement.
- Output register, per clock:
  - If (red_hit | blue_hit) and offset is in a window: delete_note<=1, score<=grade.
  - Otherwise: delete_note<=0, score<=2'b00.
- Latency: outputs are valid for exactly one cycle, starting after the same rising edge at which the press is first sampled high.
- Simultaneous red_hit and blue_hit: a single judgement is issued (only one nearest note/offset exists), and red has priority for bookkeeping. The output is identical either way.
- Out-of-window press: delete_note stays 0 and the note remains; the press is consumed, so holding the button until the note reaches the window does not score.
- Reset mid-strobe forces delete_note=0 and score=00 immediately.
- score never shows a non-zero value while delete_note=0.

Test Plan:
- Reset release, then offset=3, node_R=1, red_button 0->1 for one cycle -> delete_note=1, score=11 for exactly one cycle after that edge; both 0 afterwards.
- offset=5, node_B=1, blue_button rising -> one-cycle delete_note=1, score=10. Repeat with offset=1 on red -> score=01, and offset=6 -> score=01.
- offset=0 (and separately 7), node_B=1, blue_button rising -> delete_note stays 0, score stays 00.
- offset=4, node_R=1, red_button held high 3 cycles -> exactly one delete_note pulse with score=11. Release and re-press -> second pulse.
- Wrong lane: node_R=1, node_B=0, offset=3, blue_button rising -> no pulse. Both buttons rise together with node_R=1, offset=2 -> single pulse, score=10.
- Assert rst=0 asynchronously mid-cycle during a pulse -> delete_note=0, score=00 immediately. Button held through reset release with matching note at offset 3 -> pulse on first clock.
